pc_sequencer: RTL
=================

# pc_sequencer

Program-counter sequencer and next generation of the combinational branch-target selector. It owns the architectural PC register and resolves sequential, jump, jump-register, conditional-branch, call and return transfers with OS/user address relocation. It adds a parametrised return-address stack (RAS), a stall hold and redirect/flag outputs. It sits between the control unit/ALU compare result and the instruction ROM address port.

## Interface
Parameters:
- ADDR_W, 12: PC and target width.
- USER_BASE, 512: relocation offset added to immediate targets in user mode.
- RESET_PC, 0: PC value after reset.
- TRAP_ADDR, 0: PC loaded on RAS underflow (OS entry).
- RAS_DEPTH, 8: return-address stack entries; power of two, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  hold PC, RAS and flags this cycle.
- jump  in  1  unconditional transfer.
- jump_reg  in  1  with jump: target is an absolute register value, no relocation.
- branch  in  1  conditional transfer.
- cond  in  1  ALU compare result; branch taken when branch & cond.
- call  in  1  with jump: push return address.
- ret  in  1  pop RAS and transfer to the popped address.
- os_mode  in  1  1 = OS (no relocation), 0 = user.
- target  in  ADDR_W  immediate or register target.
- clr_flags  in  1  synchronous clear of the sticky flags.
- pc  out  ADDR_W  current PC (registered).
- redirect  out  1  registered; high in a cycle whose pc came from a non-sequential transfer.
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_overflow  out  1  sticky; a push was made while the stack was full.
- ras_underflow  out  1  sticky; a pop was made while the stack was empty.

## Operation
- Relocated target: `reloc = os_mode ? target : target + USER_BASE`, truncated mod 2^ADDR_W.
- Next-PC priority when stall=0:
  1. ret.
  2. jump & jump_reg → target, raw.
  3. jump → reloc.
  4. branch & cond → reloc.
  5. Otherwise pc+1, which wraps from 2^ADDR_W−1 to 0.
- ret, non-empty stack: next pc = top entry; pop; redirect=1.
- ret, empty stack: next pc = TRAP_ADDR; ras_underflow←1; ras_count stays 0; redirect=1.
- call & jump, not ret: push pc+1 (mod 2^ADDR_W), then transfer per jump rules.
  - Full stack: the oldest entry is overwritten (circular buffer), ras_count stays RAS_DEPTH, and ras_overflow←1.
- call without jump is ignored. call together with ret: ret wins and no push occurs.
- branch & !cond falls through to pc+1 with redirect=0.
- stall=1: pc, RAS, ras_count and flags hold; redirect←0. All control inputs are ignored.
- clr_flags clears both sticky flags at the edge. A flag-setting event in the same cycle wins, so the flag is set.
- Reset: pc=RESET_PC, ras_count=0, RAS pointer=0, redirect=0, ras_overflow=0, ras_underflow=0. RAS contents are don't-care.

## Timing
- All outputs are registered. The transfer decision is made combinationally from the inputs of cycle N and becomes visible on pc in cycle N+1. redirect is high in cycle N+1 only, which gives one-cycle transfer latency.
- Reset takes effect immediately on assertion, with no clock needed. Deassertion is synchronous to clk in the surrounding design. When reset asserts mid-operation, the RAS is discarded and the flags clear.
- A push and a pop never both occur in one cycle. Back-to-back call/ret in consecutive cycles must return the address pushed in the previous cycle.
- The stack pointer and count update in the same edge as pc.

## Test plan
- Reset, then 3 idle cycles: pc 0→1→2→3, redirect=0, flags=0.
- User mode, jump target=5: next pc=517, redirect=1. OS mode, jump target=5: pc=5. jump_reg target=700 in user mode: pc=700.
- With pc=600: branch, cond=1, target=10, user mode → pc=522. Same with cond=0 → pc=601, redirect=0. Same with stall=1 → pc stays 600.
- With pc=520: call+jump target=100, user mode → pc=612, ras_count=1. Then ret → pc=521, ras_count=0. A further ret → pc=TRAP_ADDR=0 and ras_underflow=1. clr_flags → ras_underflow=0.
- RAS_DEPTH=8 with 9 nested calls: ras_overflow=1 and ras_count=8. Nine returns yield the latest 8 return addresses in LIFO order, then a trap on the 9th.
- pc=4095 (ADDR_W=12), idle → pc=0. User target=4000 → reloc wraps to 416. Assert reset during a call sequence → pc=0 and ras_count=0 asynchronously.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Bundle between the control unit and the PC sequencer. The control unit
// drives the transfer requests; the sequencer returns the PC and RAS status.
interface pc_sequencer_if #(
  parameter int ADDR_W    = 12,
  parameter int RAS_DEPTH = 8
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic              stall;
  logic              jump;
  logic              jump_reg;
  logic              branch;
  logic              cond;
  logic              call;
  logic              ret;
  logic              os_mode;
  logic [ADDR_W-1:0] target;
  logic              clr_flags;

  logic [ADDR_W-1:0] pc;
  logic              redirect;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_overflow;
  logic              ras_underflow;

  modport master (
    output stall, jump, jump_reg, branch, cond, call, ret, os_mode, target, clr_flags,
    input  pc, redirect, ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, jump, jump_reg, branch, cond, call, ret, os_mode, target, clr_flags,
    output pc, redirect, ras_count, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC register, resolves jump, branch,
// call and return transfers, and keeps a circular return-address stack.
module pc_sequencer #(
  parameter int ADDR_W    = 12,
  parameter int USER_BASE = 512,
  parameter int RESET_PC  = 0,
  parameter int TRAP_ADDR = 0,
  parameter int RAS_DEPTH = 8
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.slave  bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q;
  logic              redirect_q;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  sp_q;
  logic              overflow_q;
  logic              underflow_q;
  logic [ADDR_W-1:0] stack [RAS_DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] reloc;
  logic [ADDR_W-1:0] pc_nxt;
  logic              redirect_nxt;
  logic [PTR_W-1:0]  sp_top;
  logic              ras_empty;
  logic              ras_full;
  logic              do_pop;
  logic              do_push;

  always_comb begin
    pc_inc    = pc_q + 1'b1;
    reloc     = bus.os_mode ? bus.target : bus.target + ADDR_W'(USER_BASE);
    sp_top    = sp_q - 1'b1;
    ras_empty = (count_q == '0);
    ras_full  = (count_q == CNT_W'(RAS_DEPTH));
    // ret has priority over call, so a cycle never both pushes and pops
    do_pop    = !bus.stall && bus.ret;
    do_push   = !bus.stall && !bus.ret && bus.call && bus.jump;

    pc_nxt       = pc_inc;
    redirect_nxt = 1'b1;
    if (bus.ret)
      pc_nxt = ras_empty ? ADDR_W'(TRAP_ADDR) : stack[sp_top];
    else if (bus.jump && bus.jump_reg)
      pc_nxt = bus.target;
    else if (bus.jump)
      pc_nxt = reloc;
    else if (bus.branch && bus.cond)
      pc_nxt = reloc;
    else
      redirect_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= ADDR_W'(RESET_PC);
      redirect_q  <= 1'b0;
      count_q     <= '0;
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.stall) begin
      redirect_q <= 1'b0;
    end else begin
      pc_q        <= pc_nxt;
      redirect_q  <= redirect_nxt;
      overflow_q  <= (do_push && ras_full) || (overflow_q && !bus.clr_flags);
      underflow_q <= (do_pop && ras_empty) || (underflow_q && !bus.clr_flags);
      if (do_pop && !ras_empty) begin
        sp_q    <= sp_top;
        count_q <= count_q - 1'b1;
      end else if (do_push) begin
        // when full, sp already points at the oldest slot, so it gets overwritten
        sp_q <= sp_q + 1'b1;
        if (!ras_full)
          count_q <= count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset)
      stack[sp_q] <= pc_inc;
  end

  assign bus.pc            = pc_q;
  assign bus.redirect      = redirect_q;
  assign bus.ras_count     = count_q;
  assign bus.ras_overflow  = overflow_q;
  assign bus.ras_underflow = underflow_q;
endmodule
